// File: rtl/axistream_pkg.sv
// Shared constants and helpers for the AXI-Stream framing blocks.
package axistream_pkg;

  localparam int AXIS_LEN_UNLIMITED = 0;
  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_LEN_WIDTH      = 16;
  localparam int DEF_COUNT_WIDTH    = 16;
  localparam int DEF_TIMEOUT        = 0;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axistream_idle_timer.sv
// Saturating idle counter; expired pulses on the edge where the count reaches LIMIT.
module axistream_idle_timer
  import axistream_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = clog2(LIMIT + 1);

  logic [W-1:0] idle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (clear) begin
      idle_cnt <= '0;
    end else if (enable && (idle_cnt != W'(LIMIT))) begin
      idle_cnt <= idle_cnt + W'(1);
    end
  end

  assign expired = !clear && enable && (idle_cnt == W'(LIMIT - 1));

endmodule

// File: rtl/axistream_packetize.sv
// One-beat holding framer: releases a beat once its successor exists or the packet is closed
// (src_tlast, add_tlast, max_len or idle timeout), with full backpressure to the source.
module axistream_packetize
  import axistream_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH   = DEF_LEN_WIDTH,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   src_tvalid,
  output logic                   src_tready,
  input  logic [DATA_WIDTH-1:0]  src_tdata,
  input  logic                   src_tlast,
  output logic                   dest_tvalid,
  input  logic                   dest_tready,
  output logic [DATA_WIDTH-1:0]  dest_tdata,
  output logic                   dest_tlast,
  input  logic                   add_tlast,
  input  logic [LEN_WIDTH-1:0]   max_len,
  output logic [COUNT_WIDTH-1:0] pkt_count,
  output logic                   cmd_dropped
);

  logic                  buf_valid;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  buf_last;
  logic                  close_flag;
  logic [LEN_WIDTH-1:0]  pkt_idx;
  logic [LEN_WIDTH:0]    idx_next;
  logic                  len_hit;
  logic                  close;
  logic                  transfer;
  logic                  load;
  logic                  timeout_hit;

  // The extra bit keeps pkt_idx+1 from wrapping before the >= compare.
  assign idx_next    = {1'b0, pkt_idx} + (LEN_WIDTH + 1)'(1);
  assign len_hit     = (max_len != LEN_WIDTH'(AXIS_LEN_UNLIMITED)) && (idx_next >= {1'b0, max_len});
  assign close       = buf_last || close_flag || add_tlast || len_hit;

  assign dest_tvalid = buf_valid && (src_tvalid || close);
  assign dest_tlast  = buf_valid && close;
  assign dest_tdata  = buf_data;
  assign transfer    = dest_tvalid && dest_tready;
  assign src_tready  = rst_n && (!buf_valid || transfer);
  assign load        = src_tvalid && src_tready;

  generate
    if (TIMEOUT > 0) begin : g_timer
      axistream_idle_timer #(
        .LIMIT (TIMEOUT)
      ) u_idle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (load),
        .enable  (buf_valid && !src_tvalid && !transfer),
        .expired (timeout_hit)
      );
    end else begin : g_no_timer
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid   <= 1'b0;
      buf_data    <= '0;
      buf_last    <= 1'b0;
      close_flag  <= 1'b0;
      pkt_idx     <= '0;
      pkt_count   <= '0;
      cmd_dropped <= 1'b0;
    end else begin
      // A command in a transfer+load cycle belongs to the outgoing beat only.
      if (load) begin
        buf_data   <= src_tdata;
        buf_last   <= src_tlast;
        buf_valid  <= 1'b1;
        close_flag <= add_tlast && !buf_valid;
      end else if (transfer) begin
        buf_valid  <= 1'b0;
        close_flag <= 1'b0;
      end else if (buf_valid) begin
        close_flag <= close_flag || add_tlast || timeout_hit;
      end

      if (transfer) begin
        pkt_idx <= dest_tlast ? '0 : pkt_idx + LEN_WIDTH'(1);
        if (dest_tlast) begin
          pkt_count <= pkt_count + COUNT_WIDTH'(1);
        end
      end

      cmd_dropped <= add_tlast && !buf_valid && !load;
    end
  end

endmodule

// File: tb/tb_axistream_packetize.sv
// Bench for axistream_packetize: directed scenarios plus random traffic against a
// queue-based reference of the held-beat framing rules.
module tb_axistream_packetize;

  localparam int TOUT = 4;

  logic        clk;
  logic        rst_n;
  logic        src_tvalid;
  logic        src_tready;
  logic [7:0]  src_tdata;
  logic        src_tlast;
  logic        dest_tvalid;
  logic        dest_tready;
  logic [7:0]  dest_tdata;
  logic        dest_tlast;
  logic        add_tlast;
  logic [15:0] max_len;
  logic [15:0] pkt_count;
  logic        cmd_dropped;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] data;
    bit         last;
    bit         closed;
    int         idle;
  } beat_t;

  beat_t       held[$];
  int          m_idx;
  logic [15:0] m_count;
  bit          m_drop;
  logic [8:0]  out_log[$];

  axistream_packetize #(
    .DATA_WIDTH  (8),
    .LEN_WIDTH   (16),
    .TIMEOUT     (TOUT),
    .COUNT_WIDTH (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_tvalid  (src_tvalid),
    .src_tready  (src_tready),
    .src_tdata   (src_tdata),
    .src_tlast   (src_tlast),
    .dest_tvalid (dest_tvalid),
    .dest_tready (dest_tready),
    .dest_tdata  (dest_tdata),
    .dest_tlast  (dest_tlast),
    .add_tlast   (add_tlast),
    .max_len     (max_len),
    .pkt_count   (pkt_count),
    .cmd_dropped (cmd_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: at most one held beat; decisions come from the framing rules each cycle.
  always @(negedge clk) begin : model
    beat_t h;
    bit hv, cl, dv, sr, xfer, load;
    if (!rst_n) begin
      held.delete();
      m_idx   = 0;
      m_count = '0;
      m_drop  = 1'b0;
    end else begin
      hv = (held.size() != 0);
      h  = '{data: 8'h00, last: 1'b0, closed: 1'b0, idle: 0};
      if (hv) h = held[0];
      cl = hv && (h.last || h.closed || add_tlast ||
                  (max_len != 16'd0 && (m_idx + 1) >= int'(max_len)));
      dv = hv && (src_tvalid || cl);
      sr = !hv || (dv && dest_tready);
      check_val("src_tready", src_tready, sr);
      check_val("dest_tvalid", dest_tvalid, dv);
      check_val("dest_tlast", dest_tlast, cl);
      if (hv) check_val("dest_tdata", dest_tdata, h.data);
      check_val("pkt_count", pkt_count, m_count);
      check_val("cmd_dropped", cmd_dropped, m_drop);
      if (dest_tvalid && dest_tready) out_log.push_back({dest_tlast, dest_tdata});

      xfer   = dv && dest_tready;
      load   = src_tvalid && sr;
      m_drop = add_tlast && !hv && !load;
      if (xfer) begin
        if (cl) begin
          m_count = m_count + 16'd1;
          m_idx   = 0;
        end else begin
          m_idx = m_idx + 1;
        end
        void'(held.pop_front());
      end else if (hv) begin
        held[0].closed = held[0].closed | add_tlast;
        if (!src_tvalid && held[0].idle < TOUT) begin
          held[0].idle = held[0].idle + 1;
          if (held[0].idle == TOUT) held[0].closed = 1'b1;
        end
      end
      if (load) held.push_back('{data: src_tdata, last: src_tlast, closed: (add_tlast && !hv), idle: 0});
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n      = 1'b0;
    src_tvalid = 1'b0;
    src_tlast  = 1'b0;
    add_tlast  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_log.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one beat and returns 1 ns after the edge that accepted it; src_tvalid stays high.
  task automatic send(input logic [7:0] d, input bit l);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    src_tvalid = 1'b1;
    src_tdata  = d;
    src_tlast  = l;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = src_tready;
      @(posedge clk); #1;
      n++;
    end
    check_val("send_handshake", ok, 1);
  endtask

  task automatic check_log(input string tag, input logic [8:0] e[$]);
    check_val({tag, "_len"}, out_log.size(), e.size());
    for (int i = 0; i < e.size() && i < out_log.size(); i++)
      check_val($sformatf("%s_%0d", tag, i), out_log[i], e[i]);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [8:0]  expq[$];
    logic [15:0] len_tab[5];
    int z;
    len_tab = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd5};

    rst_n = 1'b0; src_tvalid = 1'b0; src_tdata = '0; src_tlast = 1'b0;
    dest_tready = 1'b1; add_tlast = 1'b0; max_len = '0;
    #12;
    check_val("rst_src_tready", src_tready, 0);
    check_val("rst_dest_tvalid", dest_tvalid, 0);
    check_val("rst_dest_tlast", dest_tlast, 0);
    check_val("rst_dest_tdata", dest_tdata, 0);
    check_val("rst_pkt_count", pkt_count, 0);
    check_val("rst_cmd_dropped", cmd_dropped, 0);

    // Continuous stream terminated by src_tlast
    do_reset();
    for (int i = 1; i <= 5; i++) send(8'(i), i == 5);
    src_tvalid = 1'b0; src_tlast = 1'b0;
    idle(3);
    expq = {9'h001, 9'h002, 9'h003, 9'h004, 9'h105};
    check_log("stream", expq);
    check_val("stream_count", pkt_count, 1);

    // max_len = 3 framing, trailing beat closed later by timeout
    do_reset();
    max_len = 16'd3;
    for (int i = 0; i < 7; i++) send(8'h10 + 8'(i), 1'b0);
    src_tvalid = 1'b0;
    @(negedge clk);
    check_val("maxlen_count_mid", pkt_count, 2);
    check_val("maxlen_16_held", dest_tvalid, 0);
    idle(8);
    expq = {9'h010, 9'h011, 9'h112, 9'h013, 9'h014, 9'h115, 9'h116};
    check_log("maxlen", expq);
    check_val("maxlen_count_end", pkt_count, 3);

    // Idle timeout on a single beat
    do_reset();
    max_len = 16'd0;
    send(8'hAA, 1'b0);
    src_tvalid = 1'b0;
    z = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dest_tvalid) break;
      z++;
    end
    check_val("timeout_wait", z, TOUT);
    check_val("timeout_tlast", dest_tlast, 1);
    idle(3);
    expq = {9'h1AA};
    check_log("timeout", expq);
    check_val("timeout_count", pkt_count, 1);

    // Backpressure
    do_reset();
    dest_tready = 1'b0;
    send(8'h20, 1'b0);
    src_tdata = 8'h21;
    @(negedge clk);
    check_val("bp_ready_drop", src_tready, 0);
    idle(9);
    dest_tready = 1'b1;
    send(8'h21, 1'b0);
    send(8'h22, 1'b0);
    send(8'h23, 1'b0);
    src_tvalid = 1'b0;
    idle(10);
    expq = {9'h020, 9'h021, 9'h022, 9'h123};
    check_log("bp", expq);

    // Commands: dropped on empty buffer, sticky on a held beat
    do_reset();
    add_tlast = 1'b1;
    idle(1);
    add_tlast = 1'b0;
    @(negedge clk);
    check_val("cmd_drop_pulse", cmd_dropped, 1);
    check_val("cmd_drop_noout", dest_tvalid, 0);
    idle(1);
    dest_tready = 1'b0;
    send(8'h30, 1'b0);
    src_tvalid = 1'b0;
    idle(1);
    add_tlast = 1'b1;
    idle(1);
    add_tlast = 1'b0;
    @(negedge clk);
    check_val("cmd_sticky_valid", dest_tvalid, 1);
    check_val("cmd_sticky_last", dest_tlast, 1);
    @(posedge clk); #1;
    dest_tready = 1'b1;
    idle(2);
    expq = {9'h130};
    check_log("cmd", expq);

    // Asynchronous reset with a beat held
    do_reset();
    send(8'h41, 1'b1);
    send(8'h42, 1'b0);
    send(8'h43, 1'b0);
    dest_tready = 1'b0;
    src_tdata   = 8'h44;
    @(negedge clk);
    check_val("arst_pre_valid", dest_tvalid, 1);
    check_val("arst_pre_count", pkt_count, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_valid", dest_tvalid, 0);
    check_val("arst_ready", src_tready, 0);
    check_val("arst_count", pkt_count, 0);
    src_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_log.delete();
    max_len = 16'd2;
    dest_tready = 1'b1;
    send(8'h50, 1'b0);
    send(8'h51, 1'b0);
    send(8'h52, 1'b0);
    src_tvalid = 1'b0;
    idle(8);
    expq = {9'h050, 9'h151, 9'h152};
    check_log("arst_restart", expq);

    // Random traffic against the reference
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      src_tvalid  = ($urandom_range(0, 99) < 60);
      src_tdata   = 8'($urandom);
      src_tlast   = ($urandom_range(0, 7) == 0);
      add_tlast   = ($urandom_range(0, 15) == 0);
      dest_tready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 49) == 0) max_len = len_tab[$urandom_range(0, 4)];
      idle(1);
    end
    src_tvalid = 1'b0; add_tlast = 1'b0; dest_tready = 1'b1;
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
